// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: it narrows register data into
// byte/half/word writes with byte enables, and queues them so that a slow memory ack does not stall the pipeline.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        empty,
    output logic        addr_err,
    output logic [31:0] err_addr
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             addr_err_q, addr_err_d;
    logic [31:0]      err_addr_q, err_addr_d;

    // Only the word address is kept; the byte offset is folded into the enables.
    logic [DEPTH-1:0][29:0] ent_addr_q, ent_addr_d;
    logic [DEPTH-1:0][31:0] ent_wdata_q, ent_wdata_d;
    logic [DEPTH-1:0][3:0]  ent_be_q, ent_be_d;

    logic        full;
    logic        aligned;
    logic [3:0]  new_be;
    logic [31:0] new_wdata;
    logic        st_req;
    logic        enq;
    logic        misal;
    logic        deq;
    logic [DEPTH-1:0] hit;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign st_ready = !full;

    always_comb begin
        aligned   = 1'b1;
        new_be    = 4'b0000;
        new_wdata = 32'h0;
        case (st_op)
            2'b00: begin
                aligned   = (st_addr[1:0] == 2'b00);
                new_be    = 4'b1111;
                new_wdata = st_data;
            end
            2'b01: begin
                aligned   = !st_addr[0];
                new_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                new_wdata = {2{st_data[15:0]}};
            end
            2'b10: begin
                new_be    = 4'b0001 << st_addr[1:0];
                new_wdata = {4{st_data[7:0]}};
            end
            default: begin
                aligned   = 1'b1;
            end
        endcase
    end

    // Reserved opcode never reaches enqueue or error logic.
    assign st_req = st_valid && st_ready && (st_op != 2'b11);
    assign enq    = st_req && aligned;
    assign misal  = st_req && !aligned;
    assign deq    = !empty && mem_ack;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ent_addr_d  = ent_addr_q;
        ent_wdata_d = ent_wdata_q;
        ent_be_d    = ent_be_q;
        addr_err_d  = misal;
        err_addr_d  = err_addr_q;

        if (enq) begin
            ent_addr_d[wr_ptr_q]  = st_addr[31:2];
            ent_wdata_d[wr_ptr_q] = new_wdata;
            ent_be_d[wr_ptr_q]    = new_be;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (misal) begin
            err_addr_d = st_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_err_q <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_err_q <= addr_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Payload storage needs no reset: validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        ent_addr_q  <= ent_addr_d;
        ent_wdata_q <= ent_wdata_d;
        ent_be_q    <= ent_be_d;
    end

    assign mem_we    = !empty;
    assign mem_addr  = empty ? 32'h0 : {ent_addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata = empty ? 32'h0 : ent_wdata_q[rd_ptr_q];
    assign mem_be    = empty ? 4'b0000 : ent_be_q[rd_ptr_q];

    // An entry is live when its distance from the head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hz
        logic [PTR_W-1:0] off;
        assign off    = PTR_W'(i) - rd_ptr_q;
        assign hit[i] = ({1'b0, off} < count_q) && (ent_addr_q[i] == ld_addr[31:2]);
    end

    assign ld_hazard = |hit;
    assign addr_err  = addr_err_q;
    assign err_addr  = err_addr_q;

    logic unused_ld_lsb;
    assign unused_ld_lsb = &{1'b0, ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer: driver keeps a queue model of buffered writes,
// monitor pops the expected memory writes on every handshake.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, RSV = 2'b11;

    logic        clk = 1'b0;
    logic        reset, st_valid, mem_ack;
    logic [1:0]  st_op;
    logic [31:0] st_addr, st_data, ld_addr;
    logic        st_ready, mem_we, ld_hazard, empty, addr_err;
    logic [31:0] mem_addr, mem_wdata, err_addr;
    logic [3:0]  mem_be;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .ld_addr(ld_addr),
        .ld_hazard(ld_hazard), .empty(empty), .addr_err(addr_err),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    wr_t         mdl[$];
    wr_t         sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_err_addr = 32'h0;
    bit          armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit is_aligned(input logic [1:0] op, input logic [31:0] a);
        if (op == SW) return a % 4 == 0;
        if (op == SH) return a % 2 == 0;
        return 1'b1;
    endfunction

    // What memory should see for a store, from the sizing rules.
    function automatic wr_t shape(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        int  k;
        k       = a % 4;
        w.addr  = a - k;
        w.be    = 4'b0000;
        w.wdata = d;
        if (op == SH) begin
            w.be    = (k == 2) ? 4'b1100 : 4'b0011;
            w.wdata = {d[15:0], d[15:0]};
        end else if (op == SB) begin
            for (int b = 0; b < 4; b++) w.be[b] = (b == k);
            w.wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
        end else begin
            w.be = 4'b1111;
        end
        return w;
    endfunction

    task automatic step(input logic rst, input logic v, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic ack, input logic [31:0] ld);
        bit  hz, rdy, req;
        wr_t w;
        @(negedge clk);
        reset = rst; st_valid = v; st_op = op; st_addr = a; st_data = d;
        mem_ack = ack; ld_addr = ld;
        #1;
        if (armed) begin
            hz = 1'b0;
            foreach (mdl[i]) if (mdl[i].addr[31:2] == ld[31:2]) hz = 1'b1;
            chk("st_ready", st_ready, mdl.size() < DEPTH);
            chk("empty", empty, mdl.size() == 0);
            chk("mem_we", mem_we, mdl.size() != 0);
            chk("ld_hazard", ld_hazard, hz);
            chk("addr_err", addr_err, exp_err);
            chk("err_addr", err_addr, exp_err_addr);
            if (mdl.size() == 0) begin
                chk("idle_addr", mem_addr, 0);
                chk("idle_wdata", mem_wdata, 0);
                chk("idle_be", mem_be, 0);
            end
        end
        if (rst) begin
            mdl.delete();
            sb_q.delete();
            exp_err = 1'b0;
            exp_err_addr = 32'h0;
            armed = 1'b1;
        end else begin
            rdy = mdl.size() < DEPTH;
            req = v && rdy && (op != RSV);
            if (ack && mdl.size() > 0) void'(mdl.pop_front());
            exp_err = req && !is_aligned(op, a);
            if (exp_err) exp_err_addr = a;
            if (req && is_aligned(op, a)) begin
                w = shape(op, a, d);
                mdl.push_back(w);
                sb_q.push_back(w);
            end
        end
    endtask

    task automatic idle(input logic ack, input logic [31:0] ld);
        step(1'b0, 1'b0, SW, 32'h0, 32'h0, ack, ld);
    endtask

    // Monitor: every presented write must match the oldest outstanding store.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (armed && !reset && mem_we) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%h expected=none", mem_addr);
                end else begin
                    chk("wr_addr", mem_addr, sb_q[0].addr);
                    chk("wr_wdata", mem_wdata, sb_q[0].wdata);
                    chk("wr_be", mem_be, sb_q[0].be);
                    if (mem_ack) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_op = SW; st_addr = 0; st_data = 0;
        mem_ack = 1'b0; ld_addr = 0;
        step(1, 0, SW, 0, 0, 0, 0);
        step(1, 0, SW, 0, 0, 0, 0);
        idle(0, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", st_ready, 1);
        chk("rst_we", mem_we, 0);

        // reset with stores in flight
        step(0, 1, SW, 32'h100, 32'h11, 0, 0);
        step(0, 1, SW, 32'h104, 32'h22, 0, 0);
        step(0, 1, SW, 32'h108, 32'h33, 0, 0);
        step(1, 0, SW, 0, 0, 0, 0);
        idle(0, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_ready", st_ready, 1);
        step(0, 1, SW, 32'h10C, 32'hCAFE, 0, 0);
        idle(1, 0);
        chk("post_rst_addr", mem_addr, 32'h10C);
        idle(0, 0);
        chk("post_rst_alone", empty, 1);

        // byte store
        step(0, 1, SB, 32'h1003, 32'h123456AB, 0, 0);
        idle(1, 0);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        idle(0, 0);
        chk("sb_drained", empty, 1);

        // half then word, in order
        step(0, 1, SH, 32'h2002, 32'hFFFFBEEF, 0, 0);
        step(0, 1, SW, 32'h2004, 32'hDEADBEEF, 0, 0);
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        idle(1, 0);
        idle(1, 0);
        chk("sw_addr", mem_addr, 32'h2004);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        idle(0, 0);

        // fill, hold off, recover across pointer wrap
        for (int i = 0; i < 4; i++) step(0, 1, SW, 32'h5000 + 4 * i, 32'hA0 + i, 0, 0);
        step(0, 1, SW, 32'h5010, 32'hA4, 0, 0);
        chk("full_ready", st_ready, 0);
        step(0, 1, SW, 32'h5010, 32'hA4, 1, 0);
        step(0, 1, SW, 32'h5010, 32'hA4, 0, 0);
        chk("recover_ready", st_ready, 1);
        repeat (6) idle(1, 0);

        // misaligned stores
        step(0, 1, SW, 32'h3001, 32'h1, 0, 0);
        idle(0, 0);
        chk("mis_err", addr_err, 1);
        chk("mis_addr", err_addr, 32'h3001);
        chk("mis_we", mem_we, 0);
        idle(0, 0);
        chk("mis_err_fall", addr_err, 0);
        chk("mis_addr_hold", err_addr, 32'h3001);
        step(0, 1, SH, 32'h3003, 32'h2, 0, 0);
        idle(0, 0);
        chk("mis2_addr", err_addr, 32'h3003);
        chk("mis2_err", addr_err, 1);

        // load hazard
        step(0, 1, SB, 32'h4001, 32'h55, 0, 0);
        idle(0, 32'h4002);
        chk("hz_hit", ld_hazard, 1);
        idle(0, 32'h4004);
        chk("hz_miss", ld_hazard, 0);
        idle(1, 32'h4002);
        chk("hz_head", ld_hazard, 1);
        idle(0, 32'h4002);
        chk("hz_clear", ld_hazard, 0);

        // randomized traffic
        repeat (800) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), 32'h4000 + $urandom_range(0, 31),
                 $urandom, $urandom_range(0, 1) == 1, 32'h4000 + $urandom_range(0, 31));
        end
        repeat (8) idle(1, 0);
        chk("drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-direction counterpart of the load-path immediate/data extender: narrows 32-bit register data into byte/half/word memory writes.
- Sits between MEM stage and data memory. Accepts store requests, aligns data and generates byte enables.
- Queues stores in a small FIFO so the pipeline is not stalled by a slow memory ack.
- Flags misaligned stores instead of issuing them.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
st_valid  input  1  MEM stage presents a store this cycle
st_op  input  2  00 sw, 01 sh, 10 sb, 11 reserved (ignored)
st_addr  input  32  byte address of store
st_data  input  32  register rt value; low byte/half used for sb/sh
st_ready  output  1  buffer can accept a store (= !full)
mem_we  output  1  head entry valid, write request to memory
mem_addr  output  32  {head_addr[31:2],2'b00}
mem_wdata  output  32  aligned write data of head entry
mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i]
mem_ack  input  1  memory accepted current write this cycle
ld_addr  input  32  address of load in MEM stage
ld_hazard  output  1  some valid entry has word address == ld_addr[31:2]
empty  output  1  FIFO empty
addr_err  output  1  one-cycle pulse, cycle after a misaligned store
err_addr  output  32  address of most recent misaligned store

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr, rd_ptr and count = 0.
  - empty=1, st_ready=1, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - addr_err=0, err_addr=0, ld_hazard=0.
  - Any entry in flight at reset is discarded; no write issued.
- Accept condition: st_valid && st_ready && st_op!=11 && aligned.
  - Aligned means: sw needs addr[1:0]==00; sh needs addr[0]==0; sb is always aligned.
  - st_op==11 with st_valid is dropped silently; no error.
- Alignment at enqueue, with k = st_addr[1:0]:
  - sw: be=1111, wdata=st_data.
  - sh: be=0011 if k==00, 1100 if k==10; wdata={2{st_data[15:0]}}.
  - sb: be=0001<<k; wdata={4{st_data[7:0]}}.
  - Each entry stores addr, wdata, be.
- Misaligned store with st_valid && st_ready:
  - Not enqueued.
  - Next cycle addr_err=1 and err_addr=st_addr. addr_err falls the cycle after unless another error occurs.
  - err_addr holds until the next error.
- Memory side:
  - mem_we = !empty. mem_addr, mem_wdata and mem_be are driven combinationally from the head entry; zero when empty.
  - Head stays stable while mem_we && !mem_ack.
  - Dequeue on mem_we && mem_ack; rd_ptr wraps modulo DEPTH.
  - mem_ack while empty is ignored.
- Latency: an accepted store appears on mem_we the next cycle at the earliest. Stores are issued strictly in order.
- Full:
  - count==DEPTH gives st_ready=0. No enqueue that cycle, even if mem_ack dequeues in the same cycle.
  - st_ready recovers the cycle after the dequeue.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- ld_hazard:
  - Combinational over all valid entries, including the head.
  - Stalls dependent loads; this block does no forwarding.
- Pointer wrap: wr_ptr and rd_ptr are PTR_W bits and wrap naturally. Full/empty come from count (PTR_W+1 bits).

Test Plan:
- Reset mid-operation: enqueue 3 stores with mem_ack=0, then assert reset for 1 cycle -> empty=1, mem_we=0, st_ready=1. The next accepted store is issued alone.
- sb at 0x1003, data 0x123456AB -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB. With mem_ack=1 that cycle, empty=1 next cycle.
- sh at 0x2002, data 0xFFFFBEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF. sw at 0x2004 data 0xDEADBEEF follows in order with be=1111.
- Fill: 4 sw with mem_ack=0 -> st_ready=0. A 5th request is held off. Pulse mem_ack one cycle -> st_ready=1 the next cycle; order of issued addresses preserved across pointer wrap.
- Misaligned sw at 0x3001 -> no mem_we, addr_err=1 for exactly one cycle, err_addr=0x3001. Misaligned sh at 0x3003 -> err_addr updates to 0x3003.
- Hazard: queued sb to 0x4001 with mem_ack=0, ld_addr=0x4002 -> ld_hazard=1. ld_addr=0x4004 -> ld_hazard=0. After ack the hazard clears.
